// File: rtl/lfsr_period_gen_pkg.sv
// Shared types, reference tap masks and the LFSR step function for lfsr_period_gen.
// The step function works on a 64-bit container; only the low n bits are meaningful.
package lfsr_period_gen_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDone,
    StLocked
  } lfsr_mon_e;

  // Bit i set = tap on state[i]; term x^k maps to bit k-1.
  localparam logic [63:0] Taps4  = 64'h0000_0000_0000_000C; // x^4+x^3+1
  localparam logic [63:0] Taps8  = 64'h0000_0000_0000_00B8; // x^8+x^6+x^5+x^4+1
  localparam logic [63:0] Taps16 = 64'h0000_0000_0000_B400; // x^16+x^14+x^13+x^11+1
  localparam logic [63:0] Taps32 = 64'h0000_0000_8020_0003; // x^32+x^22+x^2+x+1
  localparam logic [63:0] Taps64 = 64'hD800_0000_0000_0000; // x^64+x^63+x^61+x^60+1

  function automatic logic [63:0] width_mask(input int unsigned n);
    logic [63:0] m;
    if (n >= 64) begin
      m = '1;
    end else begin
      m = (64'd1 << n) - 64'd1;
    end
    return m;
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input int unsigned n,
                                            input logic        galois);
    logic [63:0] m;
    logic [63:0] s;
    logic [63:0] t;
    logic [63:0] nxt;
    m = width_mask(n);
    s = state & m;
    t = taps & m;
    if (galois) begin
      nxt = (s >> 1) ^ (s[0] ? t : 64'd0);
    end else begin
      nxt = ((s << 1) | {63'd0, ^(s & t)}) & m;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lfsr_period_gen_mon.sv
// Period monitor: counts steps from the loaded seed until the LFSR returns to it,
// flags saturation of the counter and the degenerate all-zero lockup state.
module lfsr_period_gen_mon
  import lfsr_period_gen_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter int unsigned CNT_W    = 32,
  parameter logic [63:0] RST_SEED = 64'h00E7_0000_0000_E700
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [N-1:0]     seed_i,
  input  logic             step_i,
  input  logic [N-1:0]     next_state_i,
  output logic             running_o,
  output logic             period_valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic             saturated_o,
  output logic             lockup_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  lfsr_mon_e        mon_q, mon_d;
  logic [N-1:0]     ref_seed_q, ref_seed_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             saturated_q, saturated_d;

  // count_q never reaches CntMax while in StRun, so the increment cannot wrap.
  assign count_inc = count_q + CNT_W'(1);

  always_comb begin
    mon_d          = mon_q;
    ref_seed_d     = ref_seed_q;
    count_d        = count_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    saturated_d    = saturated_q;
    if (load_i) begin
      ref_seed_d  = seed_i;
      count_d     = '0;
      saturated_d = 1'b0;
      mon_d       = (seed_i != '0) ? StRun : StLocked;
    end else if (step_i) begin
      case (mon_q)
        StRun: begin
          count_d = count_inc;
          if (next_state_i == ref_seed_q) begin
            period_d       = count_inc;
            period_valid_d = 1'b1;
            mon_d          = StDone;
          end else if (count_inc == CntMax) begin
            saturated_d = 1'b1;
            mon_d       = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mon_q          <= StRun;
      ref_seed_q     <= RST_SEED[N-1:0];
      count_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      saturated_q    <= 1'b0;
    end else begin
      mon_q          <= mon_d;
      ref_seed_q     <= ref_seed_d;
      count_q        <= count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      saturated_q    <= saturated_d;
    end
  end

  assign running_o      = (mon_q == StRun);
  assign lockup_o       = (mon_q == StLocked);
  assign period_valid_o = period_valid_q;
  assign period_o       = period_q;
  assign saturated_o    = saturated_q;

endmodule

// File: rtl/lfsr_period_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load, step enable and a hardware
// period monitor that reports the number of steps needed to return to the seed.
module lfsr_period_gen
  import lfsr_period_gen_pkg::*;
#(
  parameter int unsigned N        = 64,
  parameter logic [63:0] TAPS     = 64'hD800_0000_0000_0000,
  parameter bit          GALOIS   = 1'b0,
  parameter int unsigned CNT_W    = 32,
  parameter logic [63:0] RST_SEED = 64'h00E7_0000_0000_E700
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [N-1:0]     seed_i,
  input  logic             en_i,
  output logic [N-1:0]     state_o,
  output logic             running_o,
  output logic             period_valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic             saturated_o,
  output logic             lockup_o
);

  logic [N-1:0] state_q, state_d;
  logic [N-1:0] step_val;
  logic [63:0]  step_wide;
  logic         locked;

  assign step_wide = lfsr_step(64'(state_q), TAPS, N, GALOIS);
  assign step_val  = step_wide[N-1:0];

  // Load wins over en; a locked (all-zero) state is held regardless of en.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (en_i && !locked) begin
      state_d = step_val;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_SEED[N-1:0];
    end else begin
      state_q <= state_d;
    end
  end

  lfsr_period_gen_mon #(
    .N        (N),
    .CNT_W    (CNT_W),
    .RST_SEED (RST_SEED)
  ) u_mon (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .load_i         (load_i),
    .seed_i         (seed_i),
    .step_i         (en_i),
    .next_state_i   (step_val),
    .running_o      (running_o),
    .period_valid_o (period_valid_o),
    .period_o       (period_o),
    .saturated_o    (saturated_o),
    .lockup_o       (lockup_o)
  );

  assign state_o = state_q;
  assign locked  = lockup_o;

endmodule
